// File: rtl/spu_ifetch_pkg.sv
// spu_ifetch_pkg: shared widths and the fetch-pair record used by the fetch front end
package spu_ifetch_pkg;

    localparam int LS_ADDR_W = 18;
    localparam int INSTR_W   = 32;

    typedef struct packed {
        logic [LS_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]   instr0;
        logic [INSTR_W-1:0]   instr1;
        logic                 slot0_valid;
    } fetch_pair_t;

endpackage

// File: rtl/spu_fetch_fifo.sv
// spu_fetch_fifo: DEPTH-entry queue of fetch pairs with flush, push, pop and occupancy count
module spu_fetch_fifo
    import spu_ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_pair_t                din,
    output fetch_pair_t                dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_pair_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    // pops on an empty queue are ignored; flush voids both push and pop
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && !flush;
        dout    = mem[rd_ptr];
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spu_ifetch.sv
// spu_ifetch: instruction-pair fetch front end with redirect; SPU_IFETCH_PERF_EN adds perf counters
module spu_ifetch
    import spu_ifetch_pkg::*;
#(
    parameter int                   DEPTH    = 4,
    parameter logic [LS_ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ls_req,
    output logic [LS_ADDR_W-1:0] ls_addr,
    input  logic [63:0]          ls_rdata,
    input  logic                 br_valid,
    input  logic [LS_ADDR_W-1:0] br_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LS_ADDR_W-1:0] out_pc,
    output logic [31:0]          out_instr0,
    output logic [31:0]          out_instr1,
    output logic                 out_slot0_valid
`ifdef SPU_IFETCH_PERF_EN
    ,
    output logic [31:0]          perf_starve_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]        count;
    logic [LS_ADDR_W-1:0] fetch_pc;
    logic [LS_ADDR_W-1:0] inflight_pc;
    logic                 inflight;
    logic                 inflight_skip;
    logic                 skip0;
    logic                 req_skip;
    logic                 push;
    logic                 unused_ok;
    fetch_pair_t          pair;
    fetch_pair_t          head;
    fetch_pair_t          last;
    fetch_pair_t          shown;

    // issue credit counts queued plus in-flight pairs so a response always has room
    always_comb begin
        ls_req    = rst && (br_valid || ((count + CW'(inflight)) < CW'(DEPTH)));
        ls_addr   = br_valid ? {br_target[LS_ADDR_W-1:3], 3'b000} : fetch_pc;
        req_skip  = br_valid ? br_target[2] : skip0;
        push      = inflight && !br_valid;
        pair      = '{pc: inflight_pc, instr0: ls_rdata[63:32], instr1: ls_rdata[31:0],
                      slot0_valid: !inflight_skip};
        out_valid = count != '0;
        shown     = out_valid ? head : last;
        unused_ok = ^br_target[1:0];
    end

    assign out_pc          = shown.pc;
    assign out_instr0      = shown.instr0;
    assign out_instr1      = shown.instr1;
    assign out_slot0_valid = shown.slot0_valid;

    // program counter, in-flight tracking and odd-word entry flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= {RESET_PC[LS_ADDR_W-1:3], 3'b000};
            skip0         <= RESET_PC[2];
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_skip <= 1'b0;
        end else begin
            inflight      <= ls_req;
            inflight_pc   <= ls_addr;
            inflight_skip <= req_skip;
            if (ls_req) begin
                fetch_pc <= ls_addr + LS_ADDR_W'(8);
                skip0    <= 1'b0;
            end
        end
    end

    // remembers the last presented head so outputs hold while the queue is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last <= '0;
        else if (out_valid) last <= head;
    end

    spu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (br_valid),
        .push  (push),
        .pop   (out_ready),
        .din   (pair),
        .dout  (head),
        .count (count)
    );

`ifdef SPU_IFETCH_PERF_EN
    // saturating counts of decode starvation and redirect flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_starve_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (out_ready && !out_valid && perf_starve_cnt != '1) perf_starve_cnt <= perf_starve_cnt + 32'd1;
            if (br_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spu_ifetch.sv
// tb_spu_ifetch: random and directed stimulus against a queue-based reference of the fetch front end
module tb_spu_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_req;
    logic [17:0] ls_addr;
    logic [63:0] ls_rdata;
    logic        br_valid;
    logic [17:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_pc;
    logic [31:0] out_instr0;
    logic [31:0] out_instr1;
    logic        out_slot0_valid;
`ifdef SPU_IFETCH_PERF_EN
    logic [31:0] perf_starve_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spu_ifetch dut (
        .clk             (clk),
        .rst             (rst),
        .ls_req          (ls_req),
        .ls_addr         (ls_addr),
        .ls_rdata        (ls_rdata),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr0      (out_instr0),
        .out_instr1      (out_instr1),
        .out_slot0_valid (out_slot0_valid)
`ifdef SPU_IFETCH_PERF_EN
        ,
        .perf_starve_cnt (perf_starve_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] pc;
        logic        s0;
    } ent_t;

    ent_t        q[$];
    logic        m_inf;
    logic [17:0] m_inf_pc;
    logic        m_inf_skip;
    logic [17:0] m_pc;
    logic        m_skip;
    logic [17:0] l_pc;
    logic [31:0] l_i0;
    logic [31:0] l_i1;
    logic        l_s0;
    int unsigned m_starve;
    int unsigned m_flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [17:0] a);
        return 32'hA5C0_0000 ^ {14'h0, a};
    endfunction

    task automatic model_reset();
        q.delete();
        m_inf = 1'b0; m_inf_pc = '0; m_inf_skip = 1'b0;
        m_pc = '0; m_skip = 1'b0;
        l_pc = '0; l_i0 = '0; l_i1 = '0; l_s0 = 1'b0;
        m_starve = 0; m_flush = 0;
    endtask

    // called at a falling edge; applies inputs, checks, advances the model, ends at next falling edge
    task automatic step(input logic br, input logic [17:0] tgt, input logic rdy);
        logic        e_req;
        logic [17:0] e_addr;
        logic        e_valid;
        br_valid  = br;
        br_target = tgt;
        out_ready = rdy;
        ls_rdata  = m_inf ? {word(m_inf_pc), word(m_inf_pc + 18'd4)} : {$urandom, $urandom};
        #1;
        e_req   = br || (q.size() + int'(m_inf) < 4);
        e_addr  = br ? {tgt[17:3], 3'b000} : m_pc;
        e_valid = q.size() > 0;
        check("ls_req", ls_req, e_req);
        if (e_req) check("ls_addr", ls_addr, e_addr);
        check("out_valid", out_valid, e_valid);
        if (e_valid) begin
            l_pc = q[0].pc; l_i0 = word(q[0].pc); l_i1 = word(q[0].pc + 18'd4); l_s0 = q[0].s0;
        end
        check("out_pc", out_pc, l_pc);
        check("out_instr0", out_instr0, l_i0);
        check("out_instr1", out_instr1, l_i1);
        check("out_slot0_valid", out_slot0_valid, l_s0);
`ifdef SPU_IFETCH_PERF_EN
        check("perf_starve_cnt", perf_starve_cnt, m_starve);
        check("perf_flush_cnt", perf_flush_cnt, m_flush);
        if (rdy && !e_valid) m_starve++;
        if (br) m_flush++;
`endif
        if (br) q.delete();
        else begin
            if (rdy && e_valid) void'(q.pop_front());
            if (m_inf) q.push_back('{pc: m_inf_pc, s0: !m_inf_skip});
        end
        m_inf      = e_req;
        m_inf_pc   = e_addr;
        m_inf_skip = br ? tgt[2] : m_skip;
        if (e_req) begin
            m_pc   = e_addr + 18'd8;
            m_skip = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_ls_req", ls_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 18'h0);
        check("rst_out_instr0", out_instr0, 32'h0);
        check("rst_out_instr1", out_instr1, 32'h0);
        check("rst_out_slot0", out_slot0_valid, 1'b0);
`ifdef SPU_IFETCH_PERF_EN
        check("rst_perf_starve", perf_starve_cnt, 32'h0);
        check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 9) == 0, 18'($urandom_range(0, 18'h3FFFF)), $urandom_range(0, 9) < 7);
    endtask

    initial begin
        rst = 1'b0; br_valid = 1'b0; br_target = '0; out_ready = 1'b0; ls_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        br_valid = 1'b1; br_target = 18'h1234; out_ready = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 18'h1234, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 18'h0100, 1'b1);
        step(1'b1, 18'h0200, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 18'h3FFF0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        random_run(1500);
        rst = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 18'(18'h40 * (i + 1) + 4), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        random_run(1500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
